// File: rtl/round_ctrl.sv
// round_ctrl -- game-round sequencer for the 24-game datapath.
//
// Draws four puzzle numbers from a 16-bit Galois LFSR, presents them on
// m1..m4, pulses START to the datapath, runs a per-round countdown and
// decides win/lose from the datapath's valid mask and slot-0 value.
//
// Build option: define RESTART_LIMIT_EN to cap restarts per round at
// MAX_RESTARTS. Undefined (default) means unlimited restarts.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick_1hz     one-cycle countdown strobe
//   new_game     one-cycle pulse: start a new round
//   give_up      one-cycle pulse: abandon the round as a loss
//   restart_req  one-cycle pulse: ask the datapath to restart (PLAY only)
//   valid[3:0]   datapath valid mask
//   num1[9:0]    datapath slot-0 value
//   m1..m4[9:0]  puzzle numbers, zero-extended
//   start        START level to datapath
//   restart      RESTART level to datapath
//   time_left    seconds remaining in the round
//   score        rounds won, saturating at 255
//   win, lose    round outcome levels
//   busy         high in GEN, ARM or PLAY
//   dbg_state    current FSM state encoding
//
// Handshake: there is no valid/ready traffic here. Every input request is
// a single-cycle pulse acted on in the cycle it is seen (or dropped if the
// current state does not accept it); start/restart are levels the datapath
// edge-detects, held for HOLD_CYCLES cycles.

module round_ctrl #(
   parameter int          MAX_VAL      = 13,
   parameter int          ROUND_SECS   = 60,
   parameter int          HOLD_CYCLES  = 2,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter int          MAX_RESTARTS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       new_game,
   input  logic       give_up,
   input  logic       restart_req,
   input  logic [3:0] valid,
   input  logic [9:0] num1,
   output logic [9:0] m1,
   output logic [9:0] m2,
   output logic [9:0] m3,
   output logic [9:0] m4,
   output logic       start,
   output logic       restart,
   output logic [7:0] time_left,
   output logic [7:0] score,
   output logic       win,
   output logic       lose,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_GEN  = 3'd1,
      S_ARM  = 3'd2,
      S_PLAY = 3'd3,
      S_WIN  = 3'd4,
      S_LOSE = 3'd5
   } state_t;

   localparam int          HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [3:0]  MAX_F  = 4'(MAX_VAL);

   state_t              r_state;
   state_t              w_next;

   logic [15:0]         r_lfsr;
   logic [15:0]         w_lfsr_next;
   logic [1:0]          r_idx;
   logic [3:0]          r_m1, r_m2, r_m3, r_m4;
   logic [HOLD_W-1:0]   r_arm_cnt;
   logic                r_play_seen;
   logic [7:0]          r_time;
   logic [7:0]          r_score;
   logic                r_restart;
   logic [HOLD_W-1:0]   r_rst_cnt;

   logic [3:0]          w_f;
   logic                w_accept;
   logic                w_eval;
   logic                w_tick_act;
   logic                w_play_stay;
   logic                w_rs_allow;
   logic                w_rs_issue;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

   assign w_f      = r_lfsr[3:0];
   assign w_accept = (w_f != 4'd0) && (w_f <= MAX_F);

   // The datapath needs a couple of cycles after START before its valid
   // mask means anything, so the first PLAY cycle is never evaluated.
   assign w_eval = (valid == 4'b1000) && r_play_seen;

   // A tick only counts when nothing of higher priority acts this cycle.
   assign w_tick_act = (r_state == S_PLAY) && tick_1hz && !new_game && !give_up && !w_eval;

   assign w_play_stay = (r_state == S_PLAY) && (w_next == S_PLAY);
   assign w_rs_issue  = w_play_stay && !r_restart && restart_req && w_rs_allow;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (new_game) w_next = S_GEN;
         S_GEN:  if (w_accept && (r_idx == 2'd3)) w_next = S_ARM;
         S_ARM:  if (r_arm_cnt == HOLD_W'(HOLD_CYCLES)) w_next = S_PLAY;
         S_PLAY: begin
            if (new_game)                      w_next = S_GEN;
            else if (give_up)                  w_next = S_LOSE;
            else if (w_eval)                   w_next = (num1 == 10'd24) ? S_WIN : S_LOSE;
            else if (w_tick_act && (r_time <= 8'd1)) w_next = S_LOSE;
         end
         S_WIN, S_LOSE: if (new_game) w_next = S_GEN;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      start     = (r_state == S_ARM) && (r_arm_cnt < HOLD_W'(HOLD_CYCLES));
      busy      = (r_state == S_GEN) || (r_state == S_ARM) || (r_state == S_PLAY);
      win       = (r_state == S_WIN);
      lose      = (r_state == S_LOSE);
      dbg_state = r_state;
   end

   assign m1        = {6'd0, r_m1};
   assign m2        = {6'd0, r_m2};
   assign m3        = {6'd0, r_m3};
   assign m4        = {6'd0, r_m4};
   assign restart   = r_restart;
   assign time_left = r_time;
   assign score     = r_score;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr      <= SEED;
         r_idx       <= 2'd0;
         r_m1        <= 4'd0;
         r_m2        <= 4'd0;
         r_m3        <= 4'd0;
         r_m4        <= 4'd0;
         r_arm_cnt   <= '0;
         r_play_seen <= 1'b0;
         r_time      <= 8'd0;
         r_score     <= 8'd0;
         r_restart   <= 1'b0;
         r_rst_cnt   <= '0;
      end else begin
         r_lfsr <= w_lfsr_next;

         // Rejected draws leave idx alone; idx wraps to 0 after slot 3.
         if ((r_state == S_GEN) && w_accept) begin
            case (r_idx)
               2'd0: r_m1 <= w_f;
               2'd1: r_m2 <= w_f;
               2'd2: r_m3 <= w_f;
               default: r_m4 <= w_f;
            endcase
            r_idx <= r_idx + 2'd1;
         end

         if (r_state == S_ARM) r_arm_cnt <= r_arm_cnt + HOLD_W'(1);
         else                  r_arm_cnt <= '0;

         r_play_seen <= (r_state == S_PLAY);

         if ((r_state == S_ARM) && (w_next == S_PLAY))
            r_time <= 8'(ROUND_SECS);
         else if (w_tick_act && (r_time != 8'd0))
            r_time <= r_time - 8'd1;

         if ((r_state == S_PLAY) && (w_next == S_WIN) && (r_score != 8'hFF))
            r_score <= r_score + 8'd1;

         // Leaving PLAY kills any restart pulse on the same edge.
         if (!w_play_stay) begin
            r_restart <= 1'b0;
            r_rst_cnt <= '0;
         end else if (r_restart) begin
            if (r_rst_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
               r_restart <= 1'b0;
               r_rst_cnt <= '0;
            end else begin
               r_rst_cnt <= r_rst_cnt + HOLD_W'(1);
            end
         end else if (w_rs_issue) begin
            r_restart <= 1'b1;
            r_rst_cnt <= '0;
         end
      end
   end

`ifdef RESTART_LIMIT_EN
   localparam int RS_W = ($clog2(MAX_RESTARTS + 1) < 2) ? 2 : $clog2(MAX_RESTARTS + 1);

   logic [RS_W-1:0] r_rs_issued;

   assign w_rs_allow = (r_rs_issued != RS_W'(MAX_RESTARTS));

   always_ff @(posedge clk) begin
      if (rst)
         r_rs_issued <= '0;
      else if ((r_state == S_GEN) && (w_next == S_ARM))
         r_rs_issued <= '0;
      else if (w_rs_issue)
         r_rs_issued <= r_rs_issued + RS_W'(1);
   end
`else
   // Unlimited restarts; MAX_RESTARTS only matters when the cap is built.
   assign w_rs_allow = (MAX_RESTARTS >= 0);
`endif

endmodule

// File: tb/tb_round_ctrl.sv
module tb_round_ctrl;

   localparam int          ROUND_SECS = 60;
   localparam int          HOLD       = 2;
   localparam int          MAXV       = 13;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst, tick_1hz, new_game, give_up, restart_req;
   logic [3:0] valid;
   logic [9:0] num1;
   logic [9:0] m1, m2, m3, m4;
   logic       start, restart, win, lose, busy;
   logic [7:0] time_left, score;
   logic [2:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [9:0]  exp_q[$];
   logic [15:0] m_lfsr;
   logic [7:0]  exp_score;

   round_ctrl dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .new_game(new_game),
      .give_up(give_up), .restart_req(restart_req), .valid(valid), .num1(num1),
      .m1(m1), .m2(m2), .m3(m3), .m4(m4), .start(start), .restart(restart),
      .time_left(time_left), .score(score), .win(win), .lose(lose),
      .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- clock / reference LFSR ----------------
   always #5 clk = ~clk;

   // Polynomial x^16+x^14+x^13+x^11+1, Galois right-shift form.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Reference generator state: advances every cycle outside reset.
   always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
   endtask

   // Called in the first GEN cycle; predicts the draw, follows ARM and
   // returns in the first PLAY cycle.
   task automatic follow_gen();
      logic [15:0] s;
      logic [9:0]  e1, e2, e3, e4;
      int          n, cyc, k;
      s   = m_lfsr;
      n   = 0;
      cyc = 0;
      while (n < 4) begin
         if ((s[3:0] >= 1) && (s[3:0] <= MAXV)) begin
            exp_q.push_back({6'd0, s[3:0]});
            n++;
         end
         s = lfsr_next(s);
         cyc++;
      end
      chk("gen_busy", busy, 1);
      chk("gen_win_clear", win, 0);
      chk("gen_lose_clear", lose, 0);
      chk("gen_start_low", start, 0);
      k = 0;
      while (!start && k < 64) begin
         step();
         k++;
      end
      chk("gen_cycles", k, cyc);
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      e3 = exp_q.pop_front();
      e4 = exp_q.pop_front();
      k = 0;
      while (start && k < 16) begin
         chk("arm_m1", m1, e1);
         chk("arm_m2", m2, e2);
         chk("arm_m3", m3, e3);
         chk("arm_m4", m4, e4);
         step();
         k++;
      end
      chk("start_len", k, HOLD);
      chk("settle_busy", busy, 1);
      step();
      chk("play_time", time_left, ROUND_SECS);
      chk("play_busy", busy, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k, hi, pulses, exp_pulses, v, n;
      logic prev;

      rst = 1'b1; tick_1hz = 1'b0; new_game = 1'b0; give_up = 1'b0;
      restart_req = 1'b0; valid = 4'd0; num1 = 10'd0;
      exp_score = 8'd0;
      steps(2);
      chk("rst_m1", m1, 0);
      chk("rst_m4", m4, 0);
      chk("rst_start", start, 0);
      chk("rst_time", time_left, 0);
      chk("rst_score", score, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // Requests outside PLAY do nothing.
      restart_req = 1'b1; give_up = 1'b1;
      step();
      restart_req = 1'b0; give_up = 1'b0;
      chk("idle_restart_ignored", restart, 0);
      chk("idle_stays", busy, 0);

      // Round 1: win, with an early valid that must be ignored.
      pulse_new_game();
      follow_gen();
      valid = 4'b1000; num1 = 10'd24;
      step();
      chk("early_valid_ignored", busy, 1);
      k = 0;
      while (!win && k < 4) begin step(); k++; end
      valid = 4'd0;
      exp_score = exp_score + 8'd1;
      chk("win_level", win, 1);
      chk("win_score", score, exp_score);
      tick_1hz = 1'b1; restart_req = 1'b1;
      steps(2);
      tick_1hz = 1'b0; restart_req = 1'b0;
      chk("win_time_frozen", time_left, ROUND_SECS);
      chk("win_restart_ignored", restart, 0);

      // Round 2: wrong answer.
      pulse_new_game();
      follow_gen();
      steps(3);
      valid = 4'b1000; num1 = 10'd23;
      step();
      valid = 4'd0;
      chk("wrong_lose", lose, 1);
      chk("wrong_win", win, 0);
      chk("wrong_score", score, exp_score);

      // Round 3: full countdown with randomly spaced ticks.
      pulse_new_game();
      follow_gen();
      for (int i = 1; i <= ROUND_SECS; i++) begin
         steps($urandom_range(0, 2));
         tick_1hz = 1'b1;
         step();
         tick_1hz = 1'b0;
         chk("countdown", time_left, ROUND_SECS - i);
         if (i < ROUND_SECS) chk("countdown_busy", busy, 1);
      end
      chk("timeout_lose", lose, 1);
      chk("timeout_win", win, 0);
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      chk("lose_time_frozen", time_left, 0);

      // Round 4: give_up beats a correct answer in the same cycle.
      pulse_new_game();
      follow_gen();
      steps(2);
      give_up = 1'b1; valid = 4'b1000; num1 = 10'd24;
      step();
      give_up = 1'b0; valid = 4'd0;
      chk("giveup_prio_lose", lose, 1);
      chk("giveup_prio_score", score, exp_score);

      // Round 5: new_game beats give_up; goes straight back to GEN.
      pulse_new_game();
      follow_gen();
      steps(2);
      new_game = 1'b1; give_up = 1'b1;
      step();
      new_game = 1'b0; give_up = 1'b0;
      chk("ng_prio_lose", lose, 0);
      follow_gen();

      // A second request while restart is high is dropped.
      restart_req = 1'b1;
      step();
      chk("rs_first", restart, 1);
      step();
      restart_req = 1'b0;
      chk("rs_second", restart, 1);
      step();
      chk("rs_dropped", restart, 0);
      give_up = 1'b1;
      step();
      give_up = 1'b0;

      // Round 6: four requests five cycles apart.
      pulse_new_game();
      follow_gen();
`ifdef RESTART_LIMIT_EN
      exp_pulses = 3;
`else
      exp_pulses = 4;
`endif
      hi = 0; pulses = 0; prev = restart;
      for (int c = 0; c < 25; c++) begin
         restart_req = ((c % 5) == 0) && (c < 20);
         step();
         restart_req = 1'b0;
         if (restart) hi++;
         if (restart && !prev) pulses++;
         prev = restart;
      end
      chk("rs_pulses", pulses, exp_pulses);
      chk("rs_high_cycles", hi, exp_pulses * HOLD);
      give_up = 1'b1;
      step();
      give_up = 1'b0;

      // Random answer patterns against the outcome rule.
      for (int r = 0; r < 12; r++) begin
         pulse_new_game();
         follow_gen();
         steps(2);
         v = $urandom_range(0, 15);
         if (r % 3 == 0) v = 8;
         n = ($urandom_range(0, 1) == 1) ? 24 : $urandom_range(0, 1023);
         valid = v[3:0]; num1 = n[9:0];
         step();
         valid = 4'd0;
         if (v == 8) begin
            if (n == 24) exp_score = exp_score + 8'd1;
            chk("rand_win", win, (n == 24) ? 1 : 0);
            chk("rand_lose", lose, (n == 24) ? 0 : 1);
         end else begin
            chk("rand_no_decision", busy, 1);
            give_up = 1'b1;
            step();
            give_up = 1'b0;
            chk("rand_giveup", lose, 1);
         end
         chk("rand_score", score, exp_score);
      end

      // Reset in the middle of a round.
      pulse_new_game();
      follow_gen();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_score = 8'd0;
      chk("midrst_busy", busy, 0);
      chk("midrst_m1", m1, 0);
      chk("midrst_m3", m3, 0);
      chk("midrst_time", time_left, 0);
      chk("midrst_score", score, 0);
      chk("midrst_restart", restart, 0);

      // 256 wins: score saturates.
      for (int r = 0; r < 256; r++) begin
         pulse_new_game();
         follow_gen();
         step();
         valid = 4'b1000; num1 = 10'd24;
         step();
         valid = 4'd0;
         if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
         chk("sat_win", win, 1);
         chk("sat_score", score, exp_score);
      end
      chk("sat_final", score, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
